// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2, K=3 convolutional encoder, one message bit per clock.
// Ports: clk (rising edge), rst (async, active low), enable (start, sampled in IDLE),
//        size (length code 0..3 -> N=3/4/5/7, 4..7 -> N=7), dstring (message, MSB-first in [N-1:0]),
//        rstring (2N-bit codeword, zero-extended), done (1-cycle completion pulse), busy (ENC or DONE).
module conv_encoder #(
  parameter logic [2:0] G0 = 3'b111,
  parameter logic [2:0] G1 = 3'b101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  size,
  input  logic [6:0]  dstring,
  output logic [13:0] rstring,
  output logic        done,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;
  state_t state, state_nx;
  logic [6:0] msg;
  logic [2:0] n, cnt;
  logic s1, s2, u, g0, g1, last;
  logic [13:0] acc, acc_nx;
  always_comb begin
    u        = msg[n - 3'd1 - cnt];
    g0       = ^(G0 & {u, s1, s2});
    g1       = ^(G1 & {u, s1, s2});
    last     = cnt == n - 3'd1;
    // pairs shift in at the bottom, so after N steps the first pair sits at [2N-1:2N-2]
    acc_nx   = {acc[11:0], g0, g1};
    busy     = state != IDLE;
    state_nx = state == IDLE ? (enable ? ENC : IDLE) :
               state == ENC  ? (last ? DONE : ENC) : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      msg     <= '0;
      n       <= 3'd3;
      cnt     <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      acc     <= '0;
      rstring <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && enable) begin
        msg <= dstring;
        n   <= size == 3'd0 ? 3'd3 : size == 3'd1 ? 3'd4 : size == 3'd2 ? 3'd5 : 3'd7;
        cnt <= '0;
        s1  <= 1'b0;
        s2  <= 1'b0;
        acc <= '0;
      end else if (state == ENC) begin
        acc <= acc_nx;
        s2  <= s1;
        s1  <= u;
        cnt <= cnt + 3'd1;
        if (last) begin
          rstring <= acc_nx;
          done    <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: randomized self-checking bench for conv_encoder against a behavioural model.
module tb_conv_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  size = '0;
  logic [6:0]  dstring = '0;
  logic [13:0] rstring;
  logic        done, busy;
  int ncmp = 0, nbad = 0;
  logic [13:0] prev = '0;

  conv_encoder dut (.clk(clk), .rst(rst), .enable(enable), .size(size), .dstring(dstring),
                    .rstring(rstring), .done(done), .busy(busy));

  always #5 clk = ~clk;

  function automatic int nof(input logic [2:0] s);
    return s == 3'd0 ? 3 : s == 3'd1 ? 4 : s == 3'd2 ? 5 : 7;
  endfunction

  function automatic logic [13:0] model(input logic [6:0] d, input int n);
    logic [13:0] cw;
    int s1, s2, u;
    cw = '0; s1 = 0; s2 = 0;
    for (int i = 0; i < n; i++) begin
      u = int'(d[n-1-i]);
      cw[2*n-1-2*i] = ((u + s1 + s2) % 2) == 1;
      cw[2*n-2-2*i] = ((u + s2) % 2) == 1;
      s2 = s1; s1 = u;
    end
    return cw;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic enc(input logic [2:0] sz, input logic [6:0] d);
    int n, lat, found;
    logic [13:0] exp;
    n = nof(sz);
    exp = model(d, n);
    @(negedge clk);
    enable = 1'b1; size = sz; dstring = d;
    @(posedge clk); #1;
    chk("busy_cap", busy, 1);
    enable = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      chk("hold", rstring, prev);
      size = 3'($urandom_range(0, 7));
      dstring = 7'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, n + 1);
    chk("code", rstring, exp);
    chk("busy_done", busy, 1);
    found = -1;
    for (int m = 0; m < (1 << n); m++)
      if (found < 0 && model(7'(m), n) == rstring) found = m;
    chk("decode", found, int'(d) & ((1 << n) - 1));
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("code_hold", rstring, exp);
    prev = exp;
  endtask

  task automatic b2b(input logic [2:0] sz);
    logic [13:0] q[$];
    int n, sent, got, last;
    n = nof(sz); sent = 0; got = 0; last = -1;
    @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c < 80 && got < 3; c++) begin
      if (!busy) begin
        if (sent < 3) begin
          size = sz;
          dstring = 7'($urandom);
          q.push_back(model(dstring, n));
          sent++;
        end else enable = 1'b0;
      end else begin
        size = 3'($urandom_range(0, 7));
        dstring = 7'($urandom);
      end
      @(posedge clk); #1;
      if (done) begin
        if (q.size() > 0) chk("b2b_code", rstring, q.pop_front());
        if (last >= 0) chk("b2b_gap", c - last, n + 2);
        last = c;
        got++;
        prev = rstring;
      end
    end
    chk("b2b_count", got, 3);
    enable = 1'b0;
    repeat (n + 3) @(posedge clk);
    #1;
    chk("b2b_idle", busy, 0);
  endtask

  initial begin
    #12;
    chk("rst_rstring", rstring, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    enc(3'd0, 7'b0000111); chk("tp1", rstring, 14'b00000000110110);
    enc(3'd0, 7'b0000010); chk("tp2a", rstring, 14'b00000000001110);
    enc(3'd1, 7'b0001110); chk("tp2b", rstring, 14'b00000011011001);
    enc(3'd2, 7'b0000111); chk("tp3a", rstring, 14'b00000000110110);
    enc(3'd3, 7'b1011001); chk("tp3b", rstring, 14'b11100001011111);
    enc(3'd5, 7'b1011001); chk("tp6", rstring, 14'b11100001011111);
    b2b(3'd0);
    b2b(3'd3);
    @(negedge clk);
    enable = 1'b1; size = 3'd3; dstring = 7'b1011001;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_rstring", rstring, 0);
    chk("arst_done", done, 0);
    chk("arst_busy", busy, 0);
    prev = '0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    for (int i = 0; i < 25; i++) enc(3'($urandom_range(0, 7)), 7'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
